// File: rtl/fusion_accumulator.sv
// Per-lane dot-product accumulator for quarter-unit product words.
// Define FUSION_ACC_SAT_EN for saturating lane adds and a sticky out_sat flag.
module fusion_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  input  logic                 in_last,
  input  logic [1:0]           mode,
  input  logic                 is_signed,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*ACC_W-1:0]   out_acc,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_sat
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic                      sgn_q, sgn_d;
  logic [3:0][ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [1:0]                cur_mode;
  logic                      cur_sgn;
  logic                      accept;
  logic [3:0][ACC_W-1:0]     ext;
  logic [3:0][ACC_W-1:0]     sum;
  logic [3:0]                ovf;

  // The first beat decodes with the live controls; later beats use the latched ones.
  assign cur_mode = (state_q == IDLE) ? mode : mode_q;
  assign cur_sgn  = (state_q == IDLE) ? is_signed : sgn_q;

  assign in_ready = !reset &&
                    ((state_q == IDLE && mode != 2'b11) ||
                     state_q == ACCUM);
  assign accept   = in_valid && in_ready &&
                    !(state_q == ACCUM && flush);

  always_comb begin
    ext = '0;
    unique case (cur_mode)
      2'b00: begin
        for (int k = 0; k < 4; k++) begin
          ext[k] = cur_sgn ? ACC_W'($signed(in_data[4*k +: 4]))
                           : ACC_W'(in_data[4*k +: 4]);
        end
      end
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          ext[k] = cur_sgn ? ACC_W'($signed(in_data[8*k +: 8]))
                           : ACC_W'(in_data[8*k +: 8]);
        end
      end
      2'b10: begin
        ext[0] = cur_sgn ? ACC_W'($signed(in_data))
                         : ACC_W'(in_data);
      end
      default: ext = '0;
    endcase
  end

`ifdef FUSION_ACC_SAT_EN
  logic [3:0][ACC_W:0] raw;
  logic                sat_q, sat_d;

  always_comb begin
    raw = '0;
    sum = '0;
    ovf = '0;
    for (int k = 0; k < 4; k++) begin
      raw[k] = {1'b0, acc_q[k]} + {1'b0, ext[k]};
      sum[k] = raw[k][ACC_W-1:0];
      if (sgn_q) begin
        if (acc_q[k][ACC_W-1] == ext[k][ACC_W-1] &&
            raw[k][ACC_W-1] != acc_q[k][ACC_W-1]) begin
          ovf[k] = 1'b1;
          sum[k] = acc_q[k][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end else if (raw[k][ACC_W]) begin
        ovf[k] = 1'b1;
        sum[k] = '1;
      end
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (state_q == IDLE && accept) begin
      sat_d = 1'b0;
    end else if (state_q == ACCUM && flush) begin
      sat_d = 1'b0;
    end else if (state_q == ACCUM && accept) begin
      sat_d = sat_q | (|ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign out_sat = sat_q;
`else
  always_comb begin
    ovf = '0;
    for (int k = 0; k < 4; k++) begin
      sum[k] = acc_q[k] + ext[k];
    end
  end

  assign out_sat = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = mode;
          sgn_d   = is_signed;
          acc_d   = ext;
          cnt_d   = CNT_W'(1);
          state_d = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (flush) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (accept) begin
          acc_d   = sum;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_acc   = acc_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_fusion_accumulator.sv
// Directed bench for fusion_accumulator: a 24-bit instance plus an
// 8-bit instance sharing the same stimulus for the overflow case.
module tb_fusion_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic [1:0]  mode;
  logic        is_signed;
  logic        flush;
  logic        out_ready;

  logic        rdy24, vld24, sat24;
  logic [95:0] acc24;
  logic [11:0] cnt24;
  logic        rdy8, vld8, sat8;
  logic [31:0] acc8;
  logic [11:0] cnt8;

  logic [95:0] held;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fusion_accumulator #(.ACC_W(24), .CNT_W(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy24),
    .in_data(in_data), .in_last(in_last), .mode(mode),
    .is_signed(is_signed), .flush(flush), .out_valid(vld24),
    .out_ready(out_ready), .out_acc(acc24), .out_count(cnt24),
    .out_sat(sat24)
  );

  fusion_accumulator #(.ACC_W(8), .CNT_W(12)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data), .in_last(in_last), .mode(mode),
    .is_signed(is_signed), .flush(flush), .out_valid(vld8),
    .out_ready(out_ready), .out_acc(acc8), .out_count(cnt8),
    .out_sat(sat8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    mode = 2'b00; is_signed = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", rdy24, 1'b0);
    chk("rst_out_valid", vld24, 1'b0);
    chk("rst_out_acc", acc24, 96'h0);
    chk("rst_out_count", cnt24, 12'd0);
    chk("rst_out_sat", sat24, 1'b0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", rdy24, 1'b1);

    // reserved mode blocks acceptance in IDLE
    mode = 2'b11;
    #1;
    chk("mode11_in_ready", rdy24, 1'b0);
    beat(16'h5555, 1'b1);
    chk("mode11_no_accept", vld24, 1'b0);

    // quad signed, 3 beats of F21F
    mode = 2'b00; is_signed = 1'b1;
    beat(16'hF21F, 1'b0);
    beat(16'hF21F, 1'b0);
    chk("quad_not_yet_valid", vld24, 1'b0);
    beat(16'hF21F, 1'b1);
    chk("quad_valid", vld24, 1'b1);
    chk("quad_acc", acc24, {24'hFFFFFD, 24'd6, 24'd3, 24'hFFFFFD});
    chk("quad_count", cnt24, 12'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("quad_drop_valid", vld24, 1'b0);

    // dual unsigned; mode/sign changes mid-vector are ignored
    mode = 2'b01; is_signed = 1'b0;
    beat(16'h0102, 1'b0);
    mode = 2'b00; is_signed = 1'b1;
    beat(16'h0304, 1'b1);
    chk("dual_acc", acc24, {24'd0, 24'd0, 24'd4, 24'd6});
    chk("dual_count", cnt24, 12'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // single signed: -32768 + -1
    mode = 2'b10; is_signed = 1'b1;
    beat(16'h8000, 1'b0);
    beat(16'hFFFF, 1'b1);
    chk("single_acc", acc24, {72'd0, 24'hFF7FFF});
    chk("single_count", cnt24, 12'd2);

    // backpressure in DONE; stray beats and flush must not disturb it
    held = acc24;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", rdy24, 1'b0);
      chk("bp_valid", vld24, 1'b1);
      in_valid = 1'b1; in_data = 16'h7777; flush = (i == 2);
      tick();
      chk("bp_acc_stable", acc24, held);
    end
    in_valid = 1'b0; flush = 1'b0;
    chk("bp_count_stable", cnt24, 12'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_valid_before_edge", vld24, 1'b1);
    tick();
    out_ready = 1'b0;
    chk("bp_valid_drop", vld24, 1'b0);

    // flush on 2nd beat of quad vector, then a fresh 1-beat vector
    mode = 2'b00; is_signed = 1'b1;
    beat(16'h1234, 1'b0);
    flush = 1'b1;
    beat(16'h4321, 1'b0);
    chk("flush_count_clr", cnt24, 12'd0);
    chk("flush_no_valid", vld24, 1'b0);
    beat(16'h1111, 1'b1);
    flush = 1'b0;
    chk("flush_new_valid", vld24, 1'b1);
    chk("flush_new_acc", acc24, {24'd1, 24'd1, 24'd1, 24'd1});
    chk("flush_new_count", cnt24, 12'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // signed overflow on the 8-bit instance
    mode = 2'b10; is_signed = 1'b1;
    beat(16'h0070, 1'b0);
    beat(16'h0070, 1'b1);
    chk("ovf_w24_acc", acc24, {72'd0, 24'd224});
    chk("ovf_w24_sat", sat24, 1'b0);
`ifdef FUSION_ACC_SAT_EN
    chk("ovf_w8_acc", acc8[7:0], 8'h7F);
    chk("ovf_w8_sat", sat8, 1'b1);
`else
    chk("ovf_w8_acc", acc8[7:0], 8'hE0);
    chk("ovf_w8_sat", sat8, 1'b0);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    beat(16'h0001, 1'b1);
    chk("sat_clear_new_vec", sat8, 1'b0);
    chk("w8_small_acc", acc8[7:0], 8'h01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset mid-vector discards everything
    mode = 2'b00;
    beat(16'h2222, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_count", cnt24, 12'd0);
    chk("midrst_acc", acc24, 96'h0);
    chk("midrst_valid", vld24, 1'b0);

    // counter saturates at 4095
    mode = 2'b00; is_signed = 1'b0;
    in_valid = 1'b1; in_data = 16'h0000; in_last = 1'b0;
    for (int i = 0; i < 4099; i++) tick();
    in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("cnt_sat_valid", vld24, 1'b1);
    chk("cnt_sat_count", cnt24, 12'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
